// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX input and EX output bundle for the execute stage
interface ex_stage_if #(
   parameter int ID_TO_EX_WD  = 159,
   parameter int EX_TO_MEM_WD = 76,
   parameter int EX_TO_RF_WD  = 38,
   parameter int STALL_WD     = 6
) ();
   logic [STALL_WD-1:0]     stall;
   logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
   logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
   logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus;
   logic                    inst_is_load;
   logic                    data_sram_en;
   logic [3:0]              data_sram_wen;
   logic [31:0]             data_sram_addr;
   logic [31:0]             data_sram_wdata;

   // Upstream side: supplies stall vector and decoded instruction, observes EX results
   modport master (
      output stall, id_to_ex_bus,
      input  ex_to_mem_bus, ex_to_rf_bus, inst_is_load,
      input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
   );

   // Execute stage side
   modport slave (
      input  stall, id_to_ex_bus,
      output ex_to_mem_bus, ex_to_rf_bus, inst_is_load,
      output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
   );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ID/EX register, ALU, data SRAM request
module ex_stage #(
   parameter int ID_TO_EX_WD  = 159,
   parameter int EX_TO_MEM_WD = 76,
   parameter int EX_TO_RF_WD  = 38
) (
   input  logic         clk,
   input  logic         rst,
   ex_stage_if.slave    ex_if
);
   localparam logic STOP = 1'b1;

   logic [ID_TO_EX_WD-1:0] r;
   logic                   store_done;

   logic [31:0] pc;
   logic [31:0] inst;
   logic [11:0] alu_op;
   logic [2:0]  sel_alu_src1;
   logic [3:0]  sel_alu_src2;
   logic        data_ram_en;
   logic [3:0]  data_ram_wen;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic        sel_rf_res;
   logic [31:0] rdata1;
   logic [31:0] rdata2;

   logic [31:0] src1;
   logic [31:0] src2;
   logic [31:0] alu_result;
   logic        is_store;

   logic [EX_TO_MEM_WD-1:0] mem_bus;
   logic [EX_TO_RF_WD-1:0]  rf_bus;

   assign {pc, inst, alu_op, sel_alu_src1, sel_alu_src2, data_ram_en, data_ram_wen,
           rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = r;

   assign is_store = data_ram_en & (|data_ram_wen);

   // ID/EX register: load, bubble or hold; remember that a held store has already written
   always_ff @(posedge clk) begin
      if (rst) begin
         r          <= '0;
         store_done <= 1'b0;
      end else if (ex_if.stall[2] == STOP && ex_if.stall[3] != STOP) begin
         r          <= '0;
         store_done <= 1'b0;
      end else if (ex_if.stall[2] != STOP) begin
         r          <= ex_if.id_to_ex_bus;
         store_done <= 1'b0;
      end else if (is_store && ex_if.stall[3] == STOP) begin
         store_done <= 1'b1;
      end
   end

   // Operand selection; an all-zero select yields 0
   always_comb begin
      src1 = ({32{sel_alu_src1[0]}} & rdata1)
           | ({32{sel_alu_src1[1]}} & pc)
           | ({32{sel_alu_src1[2]}} & {27'b0, inst[10:6]});
      src2 = ({32{sel_alu_src2[0]}} & rdata2)
           | ({32{sel_alu_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
           | ({32{sel_alu_src2[2]}} & 32'd8)
           | ({32{sel_alu_src2[3]}} & {16'b0, inst[15:0]});
   end

   // One-hot ALU: each enabled operation contributes its result, no op gives 0
   always_comb begin
      alu_result = 32'b0;
      if (alu_op[11]) alu_result = alu_result | (src1 + src2);
      if (alu_op[10]) alu_result = alu_result | (src1 - src2);
      if (alu_op[9])  alu_result = alu_result | {31'b0, $signed(src1) < $signed(src2)};
      if (alu_op[8])  alu_result = alu_result | {31'b0, src1 < src2};
      if (alu_op[7])  alu_result = alu_result | (src1 & src2);
      if (alu_op[6])  alu_result = alu_result | ~(src1 | src2);
      if (alu_op[5])  alu_result = alu_result | (src1 | src2);
      if (alu_op[4])  alu_result = alu_result | (src1 ^ src2);
      if (alu_op[3])  alu_result = alu_result | (src2 << src1[4:0]);
      if (alu_op[2])  alu_result = alu_result | (src2 >> src1[4:0]);
      if (alu_op[1])  alu_result = alu_result | 32'($signed(src2) >>> src1[4:0]);
      if (alu_op[0])  alu_result = alu_result | {src2[15:0], 16'b0};
   end

   assign mem_bus = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, alu_result};
   assign rf_bus  = {rf_we, rf_waddr, alu_result};

   assign ex_if.ex_to_mem_bus   = mem_bus;
   assign ex_if.ex_to_rf_bus    = rf_bus;
   assign ex_if.inst_is_load    = sel_rf_res;
   // A store that already wrote while held stays quiet until the next instruction loads
   assign ex_if.data_sram_en    = data_ram_en & ~(is_store & store_done);
   assign ex_if.data_sram_wen   = store_done ? 4'b0 : data_ram_wen;
   assign ex_if.data_sram_addr  = alu_result;
   assign ex_if.data_sram_wdata = rdata2;

   // Instruction bits and stall lanes this stage does not consume
   logic unused_bits;
   assign unused_bits = ^{inst[31:16], ex_if.stall[5:4], ex_if.stall[1:0]};
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage
module tb_ex_stage;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [11:0] op;
      logic [2:0]  s1;
      logic [3:0]  s2;
      logic        ram_en;
      logic [3:0]  wen;
      logic        rf_we;
      logic [4:0]  waddr;
      logic        sel_res;
      logic [31:0] rd1;
      logic [31:0] rd2;
   } instr_t;

   localparam logic [11:0] OP_ADD = 12'h800, OP_SLT = 12'h200, OP_SLTU = 12'h100;
   localparam logic [11:0] OP_SRA = 12'h002, OP_LUI = 12'h001;
   localparam logic [5:0]  RUN = 6'b000000, BUBBLE = 6'b000100, HOLD = 6'b001100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;

   instr_t m;
   logic   m_written;

   ex_stage_if bif ();
   ex_stage dut (.clk(clk), .rst(rst), .ex_if(bif.slave));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [158:0] got, input logic [158:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic logic [31:0] alu_ref(input instr_t i);
      logic [31:0] a, b, res;
      int idx;
      case (i.s1)
         3'b001:  a = i.rd1;
         3'b010:  a = i.pc;
         3'b100:  a = 32'(i.inst[10:6]);
         default: a = 0;
      endcase
      case (i.s2)
         4'b0001: b = i.rd2;
         4'b0010: b = 32'($signed(i.inst[15:0]));
         4'b0100: b = 8;
         4'b1000: b = 32'(i.inst[15:0]);
         default: b = 0;
      endcase
      idx = -1;
      for (int k = 0; k < 12; k++) if (i.op[k]) idx = k;
      case (idx)
         11: res = a + b;
         10: res = a - b;
         9:  res = (int'(a) < int'(b)) ? 1 : 0;
         8:  res = (a < b) ? 1 : 0;
         7:  res = a & b;
         6:  res = ~(a | b);
         5:  res = a | b;
         4:  res = a ^ b;
         3:  res = b << a[4:0];
         2:  res = b >> a[4:0];
         1:  res = 32'(int'(b) >>> a[4:0]);
         0:  res = b * 32'h10000;
         default: res = 0;
      endcase
      return res;
   endfunction

   task automatic check_all();
      logic [31:0] res;
      logic store, en;
      res   = alu_ref(m);
      store = m.ram_en && (m.wen != 0);
      en    = m.ram_en && !(store && m_written);
      check("mem_bus", 159'(bif.ex_to_mem_bus),
            159'({m.pc, m.ram_en, m.wen, m.sel_res, m.rf_we, m.waddr, res}));
      check("rf_bus", 159'(bif.ex_to_rf_bus), 159'({m.rf_we, m.waddr, res}));
      check("is_load", 159'(bif.inst_is_load), 159'(m.sel_res));
      check("sram_en", 159'(bif.data_sram_en), 159'(en));
      check("sram_wen", 159'(bif.data_sram_wen), 159'(m_written ? 4'h0 : m.wen));
      check("sram_addr", 159'(bif.data_sram_addr), 159'(res));
      check("sram_wdata", 159'(bif.data_sram_wdata), 159'(m.rd2));
   endtask

   // One clock: advance the reference model from the applied inputs, then compare
   task automatic step();
      instr_t in_i;
      in_i = instr_t'(bif.id_to_ex_bus);
      if (rst) begin
         m = '0; m_written = 0;
      end else if (bif.stall[2] && !bif.stall[3]) begin
         m = '0; m_written = 0;
      end else if (!bif.stall[2]) begin
         m = in_i; m_written = 0;
      end else if (m.ram_en && m.wen != 0 && bif.stall[3]) begin
         m_written = 1;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   function automatic instr_t mk(input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
                                 input logic [31:0] rd1, input logic [31:0] rd2,
                                 input logic [31:0] inst);
      instr_t i;
      i = '0;
      i.op = op; i.s1 = s1; i.s2 = s2; i.rd1 = rd1; i.rd2 = rd2; i.inst = inst;
      i.pc = 32'hBFC00000;
      return i;
   endfunction

   task automatic issue(input instr_t i, input logic [5:0] st);
      bif.id_to_ex_bus = i;
      bif.stall = st;
      step();
   endtask

   function automatic instr_t rand_instr();
      instr_t i;
      int k;
      i = instr_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
      k = $urandom_range(0, 3);
      i.s1 = (k == 0) ? 3'b0 : 3'(1 << (k - 1));
      k = $urandom_range(0, 4);
      i.s2 = (k == 0) ? 4'b0 : 4'(1 << (k - 1));
      k = $urandom_range(0, 12);
      i.op = (k == 12) ? 12'b0 : 12'(1 << k);
      k = $urandom_range(0, 2);
      i.wen = (k == 0) ? 4'h0 : (k == 1) ? 4'hF : i.wen;
      return i;
   endfunction

   initial begin
      instr_t i;
      int k;
      m = '0;
      m_written = 0;
      bif.stall = RUN;
      bif.id_to_ex_bus = '0;

      // Reset
      rst = 1;
      step();
      step();
      check("rst_mem_bus", 159'(bif.ex_to_mem_bus), 159'(0));
      check("rst_is_load", 159'(bif.inst_is_load), 159'(0));
      rst = 0;

      // addu wrap
      i = mk(OP_ADD, 3'b001, 4'b0001, 32'h7FFFFFFF, 32'h1, 32'h0);
      i.rf_we = 1; i.waddr = 5;
      issue(i, RUN);
      check("addu_res", 159'(bif.data_sram_addr), 159'(32'h80000000));
      check("addu_rf", 159'(bif.ex_to_rf_bus), 159'({1'b1, 5'd5, 32'h80000000}));

      // sra, slt, sltu, lui
      issue(mk(OP_SRA, 3'b100, 4'b0001, 0, 32'h80000000, 32'd4 << 6), RUN);
      check("sra", 159'(bif.ex_to_rf_bus[31:0]), 159'(32'hF8000000));
      issue(mk(OP_SLT, 3'b001, 4'b0001, 32'hFFFFFFFF, 1, 0), RUN);
      check("slt", 159'(bif.ex_to_rf_bus[31:0]), 159'(1));
      issue(mk(OP_SLTU, 3'b001, 4'b0001, 32'hFFFFFFFF, 1, 0), RUN);
      check("sltu", 159'(bif.ex_to_rf_bus[31:0]), 159'(0));
      issue(mk(OP_LUI, 3'b000, 4'b1000, 0, 0, 32'h1234), RUN);
      check("lui", 159'(bif.ex_to_rf_bus[31:0]), 159'(32'h12340000));

      // jal link address
      i = mk(OP_ADD, 3'b010, 4'b0100, 0, 0, 0);
      i.pc = 32'hBFC00010; i.rf_we = 1; i.waddr = 31;
      issue(i, RUN);
      check("jal", 159'(bif.ex_to_rf_bus), 159'({1'b1, 5'd31, 32'hBFC00018}));

      // sw held for 3 cycles: writes exactly once
      i = mk(OP_ADD, 3'b001, 4'b0010, 32'h100, 32'hDEADBEEF, 32'h0000FFFC);
      i.ram_en = 1; i.wen = 4'hF;
      issue(i, RUN);
      check("sw_addr", 159'(bif.data_sram_addr), 159'(32'hFC));
      check("sw_wdata", 159'(bif.data_sram_wdata), 159'(32'hDEADBEEF));
      check("sw_wen", 159'(bif.data_sram_wen), 159'(4'hF));
      for (int c = 0; c < 3; c++) begin
         issue(i, HOLD);
         check("sw_held_wen", 159'(bif.data_sram_wen), 159'(0));
         check("sw_held_en", 159'(bif.data_sram_en), 159'(0));
      end
      issue(i, RUN);
      check("sw_reload_wen", 159'(bif.data_sram_wen), 159'(4'hF));

      // Bubble with a lw waiting, then the lw loads
      i = mk(OP_ADD, 3'b001, 4'b0010, 32'h200, 0, 32'h8);
      i.ram_en = 1; i.sel_res = 1; i.rf_we = 1; i.waddr = 3;
      issue(i, BUBBLE);
      check("bub_load", 159'(bif.inst_is_load), 159'(0));
      check("bub_en", 159'(bif.data_sram_en), 159'(0));
      check("bub_rf_we", 159'(bif.ex_to_rf_bus[37]), 159'(0));
      issue(i, RUN);
      check("lw_load", 159'(bif.inst_is_load), 159'(1));
      check("lw_en", 159'(bif.data_sram_en), 159'(1));
      check("lw_wen", 159'(bif.data_sram_wen), 159'(0));
      issue(i, HOLD);
      check("lw_held_en", 159'(bif.data_sram_en), 159'(1));

      // Reset mid-store
      i = mk(OP_ADD, 3'b001, 4'b0010, 32'h40, 32'h55, 0);
      i.ram_en = 1; i.wen = 4'h3;
      issue(i, RUN);
      rst = 1;
      issue(i, HOLD);
      check("rst_store_wen", 159'(bif.data_sram_wen), 159'(0));
      rst = 0;
      issue(i, HOLD);
      check("rst_store_en", 159'(bif.data_sram_en), 159'(0));

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         k = $urandom_range(0, 9);
         rst = ($urandom_range(0, 39) == 0);
         issue(rand_instr(), (k < 5) ? RUN : (k < 7) ? BUBBLE : (k < 9) ? HOLD : 6'b001000);
      end
      rst = 0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
